rx_frame_20bits: RTL and testbench

- Receive-side deframer for the Bluetooth link; the consumer of the 4-byte frames that the car-side 20-bit packer transmits.
- Takes bytes from the UART byte receiver (rx_data/rx_vld pulse per byte) and reassembles them into one 20-bit word per frame.
- Resynchronises on the 0xFF terminator and rejects malformed or stalled frames.

---
 rtl/rx_frame_20bits.sv | 116 +++++++++++
 tb/tb_rx_frame_20bits.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_20bits.sv
// Receive-side deframer: rebuilds one 20-bit word from each 4-byte frame
// (B0,B1,B2,0xFF), resyncing on 0xFF and dropping malformed or stalled frames.
module rx_frame_20bits #(
  parameter int TIMEOUT_CYC = 500000,
  parameter int TO_W        = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic [19:0] rx_word,
  output logic        rx_word_vld,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        synced
);
  typedef enum logic [2:0] {
    S_HUNT, S_WAIT_B0, S_GOT_B0, S_GOT_B1, S_GOT_B2
  } state_t;

  state_t          r_state;
  logic [6:0]      r_hi;
  logic [5:0]      r_mid;
  logic [6:0]      r_lo;
  logic [TO_W-1:0] r_to;
  logic [19:0]     r_word;
  logic            r_word_vld;
  logic            r_frame_err;
  logic [7:0]      r_err_cnt;

  logic w_ff, w_in_frame, w_timeout, w_bad_byte, w_err;

  assign w_ff       = (rx_data == 8'hFF);
  assign w_in_frame = (r_state == S_GOT_B0) || (r_state == S_GOT_B1) ||
                      (r_state == S_GOT_B2);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_timeout  = w_in_frame && !rx_vld &&
                      (r_to == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_bad_byte = 1'b0;
    if (rx_vld) begin
      case (r_state)
        S_WAIT_B0: w_bad_byte = !w_ff && rx_data[0];
        S_GOT_B0:  w_bad_byte = w_ff || (rx_data[4:3] != 2'b00);
        S_GOT_B1:  w_bad_byte = rx_data[0];
        S_GOT_B2:  w_bad_byte = !w_ff;
        default:   w_bad_byte = 1'b0;
      endcase
    end
  end

  assign w_err = w_bad_byte || w_timeout;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_HUNT;
      r_hi        <= '0;
      r_mid       <= '0;
      r_lo        <= '0;
      r_to        <= '0;
      r_word      <= '0;
      r_word_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_word_vld  <= 1'b0;
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (rx_vld || !w_in_frame) r_to <= '0;
      else                       r_to <= r_to + TO_W'(1);

      if (w_timeout) begin
        r_state <= S_HUNT;
      end else if (rx_vld) begin
        case (r_state)
          S_HUNT: if (w_ff) r_state <= S_WAIT_B0;
          S_WAIT_B0:
            if (w_bad_byte) r_state <= S_HUNT;
            else if (!w_ff) begin
              r_hi    <= rx_data[7:1];
              r_state <= S_GOT_B0;
            end
          // A stray 0xFF mid-frame doubles as the sync for the next frame.
          S_GOT_B0:
            if (w_bad_byte) r_state <= w_ff ? S_WAIT_B0 : S_HUNT;
            else begin
              r_mid   <= {rx_data[7:5], rx_data[2:0]};
              r_state <= S_GOT_B1;
            end
          S_GOT_B1:
            if (w_bad_byte) r_state <= w_ff ? S_WAIT_B0 : S_HUNT;
            else begin
              r_lo    <= rx_data[7:1];
              r_state <= S_GOT_B2;
            end
          S_GOT_B2:
            if (w_ff) begin
              r_word     <= {r_hi, r_mid, r_lo};
              r_word_vld <= 1'b1;
              r_state    <= S_WAIT_B0;
            end else begin
              r_state <= S_HUNT;
            end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  assign rx_word     = r_word;
  assign rx_word_vld = r_word_vld;
  assign frame_err   = r_frame_err;
  assign err_cnt     = r_err_cnt;
  assign synced      = (r_state != S_HUNT);
endmodule

// File: tb/tb_rx_frame_20bits.sv
// Bench for rx_frame_20bits: directed scenarios plus a random byte stream,
// all checked against a frame-level reference model.
module tb_rx_frame_20bits;
  localparam int TO = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_vld = 1'b0;
  logic [19:0] rx_word;
  logic        rx_word_vld, frame_err, synced;
  logic [7:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  rx_frame_20bits #(.TIMEOUT_CYC(TO), .TO_W(20)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_vld(rx_vld),
    .rx_word(rx_word), .rx_word_vld(rx_word_vld), .frame_err(frame_err),
    .err_cnt(err_cnt), .synced(synced)
  );

  always #5 CLK = ~CLK;

  // Model: synced flag + count of data bytes collected toward the next word.
  bit          m_sync;
  int          m_n, m_idle;
  int          m_buf[3];
  logic [19:0] m_word;
  logic        m_wvld, m_err;
  logic [7:0]  m_cnt;

  logic [8:0]  sq[$];

  task automatic model_reset();
    m_sync = 0; m_n = 0; m_idle = 0; m_word = '0;
    m_wvld = 0; m_err = 0; m_cnt = '0;
  endtask

  task automatic model_fail(input bit stay);
    m_err = 1'b1;
    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    m_sync = stay;
    m_n = 0;
  endtask

  task automatic model_step(input bit v, input int d);
    m_wvld = 1'b0; m_err = 1'b0;
    if (v) begin
      m_idle = 0;
      if (!m_sync) m_sync = (d == 255);
      else if (d == 255) begin
        if (m_n == 3) begin
          m_word = 20'((m_buf[0] / 2) * 8192 + (m_buf[1] / 32) * 1024 +
                       (m_buf[1] % 8) * 128 + m_buf[2] / 2);
          m_wvld = 1'b1;
        end else if (m_n > 0) model_fail(1);
        m_n = 0;
      end else if (m_n == 3) model_fail(0);
      else if ((m_n == 1) ? ((d / 8) % 4 == 0) : (d % 2 == 0)) begin
        m_buf[m_n] = d;
        m_n++;
      end else model_fail(0);
    end else if (m_sync && m_n > 0) begin
      m_idle++;
      if (m_idle >= TO) model_fail(0);
    end
  endtask

  function automatic logic [30:0] dut_vec();
    return {rx_word, rx_word_vld, frame_err, err_cnt, synced};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {m_word, m_wvld, m_err, m_cnt, m_sync};
  endfunction

  task automatic cyc(input bit v, input logic [7:0] d);
    @(negedge CLK);
    rx_vld  = v;
    rx_data = v ? d : 8'($urandom);
    @(posedge CLK);
    model_step(v, int'(d));
    #1;
  endtask

  task automatic push(input logic [7:0] b, input int gap);
    repeat (gap) sq.push_back(9'h000);
    sq.push_back({1'b1, b});
  endtask

  // Applies the queued stream; reports cycles where DUT and model disagree.
  task automatic play(output int bad, output int wv, output int fe,
                      output logic [30:0] got, output logic [30:0] want);
    bad = 0; wv = 0; fe = 0; got = '0; want = '0;
    foreach (sq[i]) begin
      cyc(sq[i][8], sq[i][7:0]);
      if (rx_word_vld) wv++;
      if (frame_err) fe++;
      if (dut_vec() !== exp_vec()) begin
        if (bad == 0) begin got = dut_vec(); want = exp_vec(); end
        bad++;
      end
    end
    sq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    RST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    #2 RST = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== 31'd0) begin
      miscompares++; $display("FAIL reset_async: got %h want 0", dut_vec());
    end
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (dut_vec() !== 31'd0) begin
      miscompares++; $display("FAIL reset_hold: got %h want 0", dut_vec());
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_basic();
    int bad, wv, fe; logic [30:0] g, w;
    push(8'hFF, 50); push(8'hAA, 50); push(8'hE1, 50); push(8'hBC, 50); push(8'hFF, 50);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL basic_trace: got %h want %h", g, w); end
    vectors++;
    if (rx_word_vld !== 1'b1 || rx_word !== 20'hABCDE) begin
      miscompares++; $display("FAIL basic_word: got vld=%b %h want vld=1 abcde", rx_word_vld, rx_word);
    end
    vectors++;
    if (synced !== 1'b1 || err_cnt !== 8'd0 || wv !== 1) begin
      miscompares++; $display("FAIL basic_status: got sync=%b cnt=%0d pulses=%0d want 1 0 1", synced, err_cnt, wv);
    end
    cyc(0, 8'h00);
    vectors++;
    if (rx_word_vld !== 1'b0 || rx_word !== 20'hABCDE) begin
      miscompares++; $display("FAIL basic_hold: got vld=%b %h want vld=0 abcde", rx_word_vld, rx_word);
    end
  endtask

  task automatic test_idle();
    int bad, wv, fe; logic [30:0] g, w;
    repeat (10) push(8'hFF, 0);
    push(8'h00, 0); push(8'h00, 0); push(8'h00, 0); push(8'hFF, 0);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || wv !== 1 || fe !== 0 || rx_word !== 20'h0) begin
      miscompares++;
      $display("FAIL idle_zero: got bad=%0d vld=%0d err=%0d word=%h (%h/%h) want 0 1 0 00000", bad, wv, fe, rx_word, g, w);
    end
  endtask

  task automatic test_bad_b1();
    int bad, wv, fe; logic [30:0] g, w;
    push(8'hAA, 2); push(8'hE9, 2);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || frame_err !== 1'b1 || synced !== 1'b0) begin
      miscompares++; $display("FAIL badb1_err: got err=%b sync=%b bad=%0d want 1 0 0", frame_err, synced, bad);
    end
    push(8'hBC, 2); push(8'hFF, 2); push(8'hAA, 2); push(8'hE1, 2); push(8'hBC, 2); push(8'hFF, 2);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 0 || wv !== 1 || rx_word !== 20'hABCDE || err_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL badb1_resync: got bad=%0d err=%0d vld=%0d word=%h cnt=%0d want 0 0 1 abcde 1", bad, fe, wv, rx_word, err_cnt);
    end
  endtask

  task automatic test_ff_midframe();
    int bad, wv, fe; logic [30:0] g, w;
    push(8'hAA, 1); push(8'hE1, 1); push(8'hFF, 1);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || frame_err !== 1'b1 || synced !== 1'b1) begin
      miscompares++; $display("FAIL ffmid_err: got err=%b sync=%b bad=%0d want 1 1 0", frame_err, synced, bad);
    end
    push(8'hAA, 1); push(8'hE1, 1); push(8'hBC, 1); push(8'hFF, 1);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 0 || wv !== 1 || rx_word !== 20'hABCDE || err_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL ffmid_next: got bad=%0d err=%0d vld=%0d word=%h cnt=%0d want 0 0 1 abcde 2", bad, fe, wv, rx_word, err_cnt);
    end
  endtask

  task automatic test_timeout();
    int bad, wv, fe; logic [30:0] g, w;
    push(8'hAA, 0);
    repeat (TO - 1) sq.push_back(9'h000);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 0 || synced !== 1'b1) begin
      miscompares++; $display("FAIL timeout_early: got err=%0d sync=%b bad=%0d want 0 1 0", fe, synced, bad);
    end
    sq.push_back(9'h000);
    play(bad, wv, fe, g, w);
    vectors++;
    if (frame_err !== 1'b1 || synced !== 1'b0 || err_cnt !== 8'd3) begin
      miscompares++; $display("FAIL timeout_fire: got err=%b sync=%b cnt=%0d want 1 0 3", frame_err, synced, err_cnt);
    end
    repeat (20) sq.push_back(9'h000);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 0) begin
      miscompares++; $display("FAIL timeout_once: got extra_err=%0d bad=%0d want 0 0", fe, bad);
    end
    // Byte on idle cycle 99, then one exactly on the expiry cycle.
    push(8'hFF, 0); push(8'hAA, 0); push(8'hE1, TO - 2); push(8'hBC, TO - 1); push(8'hFF, TO - 1);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 0 || wv !== 1 || rx_word !== 20'hABCDE) begin
      miscompares++;
      $display("FAIL timeout_edge: got bad=%0d err=%0d vld=%0d word=%h want 0 0 1 abcde", bad, fe, wv, rx_word);
    end
  endtask

  task automatic test_async_reset();
    int bad, wv, fe; logic [30:0] g, w;
    push(8'hFF, 0); push(8'hAA, 0); push(8'hE1, 0);
    play(bad, wv, fe, g, w);
    @(negedge CLK); #2;
    RST = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== 31'd0) begin
      miscompares++; $display("FAIL midreset: got %h want 0", dut_vec());
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    push(8'hBC, 1); push(8'hFF, 1); push(8'hAA, 1); push(8'hE1, 1); push(8'hBC, 1); push(8'hFF, 1);
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 0 || wv !== 1 || rx_word !== 20'hABCDE) begin
      miscompares++;
      $display("FAIL postreset: got bad=%0d err=%0d vld=%0d word=%h want 0 0 1 abcde", bad, fe, wv, rx_word);
    end
  endtask

  task automatic test_saturate();
    int bad, wv, fe; logic [30:0] g, w;
    repeat (300) begin push(8'hFF, 0); push(8'h01, 0); end
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0 || fe !== 300 || err_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate: got bad=%0d errs=%0d cnt=%0d want 0 300 255", bad, fe, err_cnt);
    end
  endtask

  task automatic test_random();
    int bad, wv, fe, k, n, wd; logic [30:0] g, w;
    logic [7:0] fb[4];
    do_reset();
    repeat (400) begin
      k = $urandom_range(0, 9);
      if (k <= 5 || k == 9) begin
        wd = $urandom_range(0, 20'hFFFFF);
        fb[0] = 8'((wd / 8192) * 2);
        fb[1] = 8'(((wd / 1024) % 8) * 32 + (wd / 128) % 8);
        fb[2] = 8'((wd % 128) * 2);
        fb[3] = 8'hFF;
        n = (k == 9) ? $urandom_range(1, 3) : 4;
        for (int i = 0; i < n; i++) push(fb[i], $urandom_range(0, 3));
      end else if (k == 6) push(8'($urandom), $urandom_range(0, 3));
      else if (k == 7) push(8'hFF, 0);
      else repeat ($urandom_range(95, 105)) sq.push_back(9'h000);
    end
    play(bad, wv, fe, g, w);
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL random_trace: %0d bad cycles, first got %h want %h", bad, g, w);
    end
    vectors++;
    if (wv == 0 || fe == 0) begin
      miscompares++; $display("FAIL random_activity: got words=%0d errs=%0d want both nonzero", wv, fe);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle();
    test_bad_b1();
    test_ff_midframe();
    test_timeout();
    test_async_reset();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
